// File: rtl/odd_even_sort_pipe_pkg.sv
// Shared definitions for the odd-even transposition sorter pipeline.
package odd_even_sort_pipe_pkg;

  // Per-vector sort direction that travels alongside the keys.
  typedef enum logic {
    MODE_ASC  = 1'b0,
    MODE_DESC = 1'b1
  } sort_mode_e;

  // Stage parity decides which lane pairing a layer uses.
  function automatic logic stage_is_odd(input int unsigned s);
    return (s % 2) != 0;
  endfunction

  // Number of compare-exchange cells a layer needs for n lanes.
  function automatic int unsigned pairs_in_stage(input int unsigned n, input int unsigned s);
    if (stage_is_odd(s)) begin
      return (n / 2) - 1;
    end else begin
      return n / 2;
    end
  endfunction

endpackage

// File: rtl/odd_even_sort_pipe_cmp_swap.sv
// Combinational two-key compare-exchange cell.
// 'a' is the lower lane and 'b' the upper lane; 'lo'/'hi' are the lanes after
// the exchange. Equal keys never swap so the network stays stable.
module cmp_swap
  import odd_even_sort_pipe_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap_s;

  // Decide the exchange from the unsigned ordering and the vector's mode.
  always_comb begin
    swap_s = 1'b0;
    lo     = a;
    hi     = b;
    if (desc == MODE_DESC) begin
      swap_s = (a < b);
    end else begin
      swap_s = (a > b);
    end
    if (swap_s) begin
      lo = b;
      hi = a;
    end else begin
      lo = a;
      hi = b;
    end
  end

endmodule

// File: rtl/odd_even_sort_pipe.sv
// Fully pipelined odd-even transposition sorter: N lanes of W-bit keys,
// one vector per cycle, per-vector asc/desc mode, valid/ready backpressure.
// All stages advance together on a single global enable so the pipeline
// behaves as one elastic shift register.
module odd_even_sort_pipe
  import odd_even_sort_pipe_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_desc,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_desc,
  output logic [N*W-1:0] out_data
);

  logic           adv_s;
  logic           stage_valid_r [N];
  logic           stage_desc_r  [N];
  logic [N*W-1:0] stage_data_r  [N];

  logic           stage_valid_in_s [N];
  logic           stage_desc_in_s  [N];
  logic [N*W-1:0] stage_keys_in_s  [N];

  // Global advance: the tail is empty or the consumer is taking it.
  always_comb begin
    adv_s = !stage_valid_r[N-1] || out_ready;
  end

  assign in_ready  = adv_s && !rst;
  assign out_valid = stage_valid_r[N-1];
  assign out_desc  = stage_desc_r[N-1];
  assign out_data  = stage_data_r[N-1];

  for (genvar s = 0; s < N; s++) begin : g_stage
    logic [N*W-1:0] layer_s;

    // Stage input: the producer for stage 0, the previous register otherwise.
    if (s == 0) begin : g_head
      assign stage_valid_in_s[s] = in_valid && in_ready;
      assign stage_desc_in_s[s]  = in_desc;
      assign stage_keys_in_s[s]  = in_data;
    end else begin : g_link
      assign stage_valid_in_s[s] = stage_valid_r[s-1];
      assign stage_desc_in_s[s]  = stage_desc_r[s-1];
      assign stage_keys_in_s[s]  = stage_data_r[s-1];
    end

    if (!stage_is_odd(s)) begin : g_even
      // Even layer pairs (0,1),(2,3),...
      for (genvar p = 0; p < pairs_in_stage(N, s); p++) begin : g_pair
        cmp_swap #(.W(W)) u_cmp_swap (
          .a    (stage_keys_in_s[s][(2*p)*W +: W]),
          .b    (stage_keys_in_s[s][(2*p+1)*W +: W]),
          .desc (stage_desc_in_s[s]),
          .lo   (layer_s[(2*p)*W +: W]),
          .hi   (layer_s[(2*p+1)*W +: W])
        );
      end
    end else begin : g_odd
      // Odd layer pairs (1,2),(3,4),...; the outer lanes pass straight through.
      assign layer_s[0 +: W]       = stage_keys_in_s[s][0 +: W];
      assign layer_s[(N-1)*W +: W] = stage_keys_in_s[s][(N-1)*W +: W];
      for (genvar p = 0; p < pairs_in_stage(N, s); p++) begin : g_pair
        cmp_swap #(.W(W)) u_cmp_swap (
          .a    (stage_keys_in_s[s][(2*p+1)*W +: W]),
          .b    (stage_keys_in_s[s][(2*p+2)*W +: W]),
          .desc (stage_desc_in_s[s]),
          .lo   (layer_s[(2*p+1)*W +: W]),
          .hi   (layer_s[(2*p+2)*W +: W])
        );
      end
    end

    // Stage register: cleared by reset, shifts on advance, holds on stall.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_valid_r[s] <= 1'b0;
        stage_desc_r[s]  <= 1'b0;
        stage_data_r[s]  <= {(N*W){1'b0}};
      end else if (adv_s) begin
        stage_valid_r[s] <= stage_valid_in_s[s];
        stage_desc_r[s]  <= stage_desc_in_s[s];
        stage_data_r[s]  <= layer_s;
      end else begin
        stage_valid_r[s] <= stage_valid_r[s];
        stage_desc_r[s]  <= stage_desc_r[s];
        stage_data_r[s]  <= stage_data_r[s];
      end
    end
  end

endmodule

// File: tb/tb_odd_even_sort_pipe.sv
// Self-checking bench for odd_even_sort_pipe: a 4x4 instance for the directed
// scenarios and an 8x8 instance for a randomized scoreboard run.
module tb_odd_even_sort_pipe;

  localparam int AN = 4;
  localparam int AW = 4;
  localparam int BN = 8;
  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           a_in_valid, a_in_ready, a_in_desc;
  logic [AN*AW-1:0] a_in_data;
  logic           a_out_valid, a_out_ready, a_out_desc;
  logic [AN*AW-1:0] a_out_data;

  logic           b_in_valid, b_in_ready, b_in_desc;
  logic [BN*BW-1:0] b_in_data;
  logic           b_out_valid, b_out_ready, b_out_desc;
  logic [BN*BW-1:0] b_out_data;

  int checks = 0;
  int errors = 0;

  odd_even_sort_pipe #(.N(AN), .W(AW)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_desc(a_in_desc), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_desc(a_out_desc), .out_data(a_out_data)
  );

  odd_even_sort_pipe #(.N(BN), .W(BW)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_desc(b_in_desc), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_desc(b_out_desc), .out_data(b_out_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unpack keys, sort them as integers, repack with lane 0 first.
  function automatic logic [63:0] ref_sort(input logic [63:0] v, input int n, input int w,
                                           input logic desc);
    int keys[$];
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    r = 64'd0;
    for (int i = 0; i < n; i++) keys.push_back(int'((v >> (i * w)) & mask));
    if (desc) keys.rsort();
    else keys.sort();
    for (int i = 0; i < n; i++) r = r | (64'(keys[i]) << (i * w));
    return r;
  endfunction

  // Push one vector into the idle 4x4 pipe and check latency and result.
  task automatic a_single(input logic [15:0] data, input logic desc, input logic [15:0] exp,
                          input string name);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = data;
    a_in_desc   = desc;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready got %b want 1", name, a_in_ready);
    end
    tick();
    a_in_valid = 1'b0;
    a_in_data  = 16'($urandom);
    repeat (AN - 2) tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid got %b want 0", name, a_out_valid);
    end
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== exp || a_out_desc !== desc) begin
      errors++;
      $display("FAIL %s result got v=%b d=%h m=%b want v=1 d=%h m=%b",
               name, a_out_valid, a_out_data, a_out_desc, exp, desc);
    end
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s drained got %b want 0", name, a_out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_desc = 1'b0; a_in_data = 16'h0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_desc = 1'b0; b_in_data = 64'h0; b_out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_out_data !== 16'h0 ||
        a_out_desc !== 1'b0 || b_out_valid !== 1'b0 || b_out_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b d=%h m=%b bv=%b bd=%h want 0",
               a_in_ready, a_out_valid, a_out_data, a_out_desc, b_out_valid, b_out_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready got %b want 1", a_in_ready);
    end
  endtask

  task automatic test_basic();
    a_single(16'h1426, 1'b0, 16'h6421, "asc_6241");
    a_single(16'h1426, 1'b1, 16'h1246, "desc_6241");
  endtask

  task automatic test_boundaries();
    a_single(16'h03F3, 1'b0, 16'hF330, "dup_asc");
    a_single(16'h7777, 1'b0, 16'h7777, "all_equal_asc");
    a_single(16'h7777, 1'b1, 16'h7777, "all_equal_desc");
    a_single(16'h0F0F, 1'b0, 16'hFF00, "max_keys_asc");
  endtask

  task automatic test_back_to_back();
    logic [15:0] vecs [5];
    logic        descs[5];
    logic [15:0] expq [$];
    logic        expd [$];
    logic [15:0] held;
    logic [63:0] r;
    int sent = 0, got = 0, stall_left = 0;
    bit stalled_once = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vecs[i]  = 16'($urandom);
      descs[i] = 1'(i % 2);
    end
    held = 16'h0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      if (sent < 5) begin
        a_in_valid = 1'b1; a_in_data = vecs[sent]; a_in_desc = descs[sent];
      end else begin
        a_in_valid = 1'b0;
      end
      if (!stalled_once && a_out_valid === 1'b1) begin
        stalled_once = 1'b1;
        stall_left   = 3;
        held         = a_out_data;
      end
      a_out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        checks++;
        if (a_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stall_ready got %b want 0", a_in_ready);
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== held) begin
          errors++;
          $display("FAIL b2b_stall_hold got v=%b d=%h want v=1 d=%h", a_out_valid, a_out_data, held);
        end
        stall_left--;
      end
      if (a_out_valid === 1'b1 && a_out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got d=%h want nothing", a_out_data);
        end else if (a_out_data !== expq[0] || a_out_desc !== expd[0]) begin
          errors++;
          $display("FAIL b2b_order got d=%h m=%b want d=%h m=%b",
                   a_out_data, a_out_desc, expq[0], expd[0]);
        end
        if (expq.size() != 0) begin
          void'(expq.pop_front());
          void'(expd.pop_front());
        end
        got++;
      end
      if (a_in_valid && a_in_ready === 1'b1) begin
        r = ref_sort(64'(a_in_data), AN, AW, a_in_desc);
        expq.push_back(r[15:0]);
        expd.push_back(a_in_desc);
        sent++;
      end
      tick();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    checks++;
    if (got != 5 || sent != 5 || !stalled_once) begin
      errors++;
      $display("FAIL b2b_count got out=%0d in=%0d stall=%0d want 5 5 1", got, sent, stalled_once);
    end
    repeat (AN + 1) tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_dup got v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_reset_flush();
    logic [63:0] r;
    logic [15:0] v;
    int seen = 0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_data = 16'($urandom); a_in_desc = 1'($urandom);
      tick();
    end
    a_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_in_rst got %b want 0", a_in_ready);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 16'h0 || a_out_desc !== 1'b0) begin
      errors++;
      $display("FAIL flush_cleared got v=%b d=%h m=%b want 0 0 0", a_out_valid, a_out_data, a_out_desc);
    end
    for (int i = 0; i < 2 * AN; i++) begin
      tick();
      if (a_out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_leak got %0d valid cycles want 0", seen);
    end
    v = 16'($urandom);
    r = ref_sort(64'(v), AN, AW, 1'b1);
    a_single(v, 1'b1, r[15:0], "after_reset");
  endtask

  task automatic test_random_n8();
    logic [63:0] expq[$];
    logic        expd[$];
    logic [63:0] pend, prev_data;
    logic        pend_desc, prev_desc, prev_stalled;
    bit have_pend = 1'b0;
    bit dup_mode;
    int sent = 0, got = 0;
    pend = 64'h0; pend_desc = 1'b0;
    prev_data = 64'h0; prev_desc = 1'b0; prev_stalled = 1'b0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      if (!have_pend && sent < 1000 && $urandom_range(0, 9) < 7) begin
        dup_mode = 1'($urandom);
        for (int i = 0; i < BN; i++) begin
          if (dup_mode) pend[i*BW +: BW] = 8'($urandom_range(0, 3));
          else pend[i*BW +: BW] = 8'($urandom_range(0, 255));
        end
        pend_desc = 1'($urandom);
        have_pend = 1'b1;
      end
      b_in_valid  = have_pend;
      b_in_data   = pend;
      b_in_desc   = pend_desc;
      b_out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (prev_stalled) begin
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== prev_data || b_out_desc !== prev_desc) begin
          errors++;
          $display("FAIL rnd_hold got v=%b d=%h m=%b want v=1 d=%h m=%b",
                   b_out_valid, b_out_data, b_out_desc, prev_data, prev_desc);
        end
      end
      if (b_out_valid === 1'b1 && b_out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra got d=%h want nothing", b_out_data);
        end else begin
          if (b_out_data !== expq[0] || b_out_desc !== expd[0]) begin
            errors++;
            $display("FAIL rnd_sort got d=%h m=%b want d=%h m=%b",
                     b_out_data, b_out_desc, expq[0], expd[0]);
          end
          void'(expq.pop_front());
          void'(expd.pop_front());
        end
        got++;
      end
      if (b_in_valid && b_in_ready === 1'b1) begin
        expq.push_back(ref_sort(b_in_data, BN, BW, b_in_desc));
        expd.push_back(b_in_desc);
        have_pend = 1'b0;
        sent++;
      end
      prev_stalled = (b_out_valid === 1'b1) && !b_out_ready;
      prev_data    = b_out_data;
      prev_desc    = b_out_desc;
      tick();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    checks++;
    if (got != 1000 || expq.size() != 0) begin
      errors++;
      $display("FAIL rnd_count got out=%0d pending=%0d want 1000 0", got, expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_flush();
    test_random_n8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
